// File: rtl/iob_bus_arbiter.sv
// iob_bus_arbiter: two-master round-robin arbiter onto one shared IOb slave port.
// At most one slave transaction is outstanding. An optional watchdog completes a
// stalled transfer toward its master with zero read data and sets a sticky flag.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   m0_* (valid/addr/wdata/wstrb) master 0 (CPU data bus) request
//   m0_rdata, m0_ready            master 0 response (pass-through of the slave)
//   m1_* (valid/addr/wdata/wstrb) master 1 (CPU instruction bus) request
//   m1_rdata, m1_ready            master 1 response
//   s_valid/addr/wdata/wstrb      shared slave request (from latched payload)
//   s_rdata, s_ready              shared slave response
//   timeout_err                   sticky watchdog flag, cleared only by reset
module iob_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready,
  output logic                timeout_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q, state_nxt;
  logic                last_q, last_nxt;   // index of the last completed grant
  logic                gnt_q, gnt_nxt;     // index of the master being serviced
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic [STRB_W-1:0]   wstrb_q, wstrb_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic                terr_q, terr_nxt;
  logic                sel_c;
  logic                expire_c;
  logic                done_c;

  // State and payload registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      last_q  <= last_nxt;
      gnt_q   <= gnt_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      wstrb_q <= wstrb_nxt;
      cnt_q   <= cnt_nxt;
      terr_q  <= terr_nxt;
    end
  end

  // Arbitration, next-state and watchdog
  always_comb begin
    state_nxt = state_q;
    last_nxt  = last_q;
    gnt_nxt   = gnt_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    wstrb_nxt = wstrb_q;
    cnt_nxt   = cnt_q;
    terr_nxt  = terr_q;
    sel_c     = 1'b0;
    expire_c  = 1'b0;
    done_c    = 1'b0;

    case (state_q)
      IDLE: begin
        // m1 wins if it is alone, or on a tie when m0 was granted last.
        sel_c = m1_valid && (!m0_valid || !last_q);
        if (m0_valid || m1_valid) begin
          gnt_nxt   = sel_c;
          addr_nxt  = sel_c ? m1_addr  : m0_addr;
          wdata_nxt = sel_c ? m1_wdata : m0_wdata;
          wstrb_nxt = sel_c ? m1_wstrb : m0_wstrb;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A real response in the expiry cycle takes precedence over the watchdog.
        expire_c = (TIMEOUT != 0) && !s_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
        done_c   = s_ready || expire_c;
        if (done_c) begin
          state_nxt = IDLE;
          last_nxt  = gnt_q;
          if (expire_c) begin
            terr_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Slave request comes straight from the latched registers.
  assign s_valid     = (state_q == BUSY);
  assign s_addr      = addr_q;
  assign s_wdata     = wdata_q;
  assign s_wstrb     = wstrb_q;
  assign timeout_err = terr_q;

  // Response is routed to the granted master only; a watchdog completion returns zero.
  assign m0_ready = done_c && !gnt_q;
  assign m1_ready = done_c && gnt_q;
  assign m0_rdata = (m0_ready && s_ready) ? s_rdata : '0;
  assign m1_rdata = (m1_ready && s_ready) ? s_rdata : '0;

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// tb_iob_bus_arbiter: directed self-checking bench for iob_bus_arbiter (TIMEOUT=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_iob_bus_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m0_valid, m1_valid;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic [STRB_W-1:0] m0_wstrb, m1_wstrb;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              m0_ready, m1_ready;
  logic              s_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic [DATA_W-1:0] s_rdata;
  logic              s_ready;
  logic              timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  always #5 clk = ~clk;

  iob_bus_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_valid   (m0_valid),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_rdata   (m0_rdata),
    .m0_ready   (m0_ready),
    .m1_valid   (m1_valid),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_rdata   (m1_rdata),
    .m1_ready   (m1_ready),
    .s_valid    (s_valid),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_rdata    (s_rdata),
    .s_ready    (s_ready),
    .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata = '0;

    // Reset state
    tick(); tick();
    sample();
    chk1 ("rst_s_valid", s_valid, 1'b0);
    chk1 ("rst_m0_ready", m0_ready, 1'b0);
    chk1 ("rst_m1_ready", m1_ready, 1'b0);
    chk1 ("rst_timeout_err", timeout_err, 1'b0);
    chk32("rst_s_addr", s_addr, 32'h0);
    chk32("rst_m0_rdata", m0_rdata, 32'h0);
    tick(); rst_n = 1'b1;

    // Single read from m1, slave answers in the third BUSY cycle
    tick(); m1_valid = 1'b1; m1_addr = 32'h100; m1_wstrb = 4'h0; m1_wdata = 32'h0;
    sample(); chk1("rd_c0_s_valid", s_valid, 1'b0);
    tick();
    sample(); chk1("rd_c1_s_valid", s_valid, 1'b1);
    chk32("rd_c1_s_addr", s_addr, 32'h100);
    chk32("rd_c1_s_wstrb", 32'(s_wstrb), 32'h0);
    chk1 ("rd_c1_m1_ready", m1_ready, 1'b0);
    tick();
    sample(); chk1("rd_c2_m1_ready", m1_ready, 1'b0);
    tick(); s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
    sample(); chk1("rd_c3_m1_ready", m1_ready, 1'b1);
    chk32("rd_c3_m1_rdata", m1_rdata, 32'hDEADBEEF);
    chk1 ("rd_c3_m0_ready", m0_ready, 1'b0);
    chk32("rd_c3_m0_rdata", m0_rdata, 32'h0);
    tick(); m1_valid = 1'b0; s_ready = 1'b0;
    sample(); chk1("rd_c4_s_valid", s_valid, 1'b0);
    chk32("rd_c4_m1_rdata", m1_rdata, 32'h0);

    // Write from m0: payload must reach the slave unchanged and stay stable
    tick(); m0_valid = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h12345678; m0_wstrb = 4'hF;
    sample(); chk1("wr_c0_s_valid", s_valid, 1'b0);
    tick();
    sample(); chk1("wr_c1_s_valid", s_valid, 1'b1);
    chk32("wr_c1_s_addr", s_addr, 32'h20);
    chk32("wr_c1_s_wdata", s_wdata, 32'h12345678);
    chk32("wr_c1_s_wstrb", 32'(s_wstrb), 32'hF);
    tick(); s_ready = 1'b1; s_rdata = 32'h00000055;
    sample(); chk32("wr_c2_s_wdata", s_wdata, 32'h12345678);
    chk1 ("wr_c2_m0_ready", m0_ready, 1'b1);
    chk32("wr_c2_m0_rdata", m0_rdata, 32'h00000055);
    chk1 ("wr_c2_m1_ready", m1_ready, 1'b0);
    tick(); m0_valid = 1'b0; s_ready = 1'b0;
    sample(); chk32("wr_c3_m0_rdata", m0_rdata, 32'h0);

    // Reset, then both masters valid from release; s_ready held high also covers IDLE ignore
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'hA0; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'hB0; m1_wstrb = 4'h0;
    s_ready  = 1'b1; s_rdata = 32'h1000;
    sample(); chk1("tie0_idle_m0_ready", m0_ready, 1'b0);
    chk1 ("tie0_idle_m1_ready", m1_ready, 1'b0);
    tick();
    sample(); chk32("tie0_s_addr", s_addr, 32'hA0);
    chk1 ("tie0_m0_ready", m0_ready, 1'b1);
    chk32("tie0_m0_rdata", m0_rdata, 32'h1000);
    chk1 ("tie0_m1_ready", m1_ready, 1'b0);
    tick(); m0_addr = 32'hA4; s_rdata = 32'h2000;
    sample(); chk1("tie1_idle_s_valid", s_valid, 1'b0);
    chk1 ("tie1_idle_m1_ready", m1_ready, 1'b0);
    tick();
    sample(); chk32("tie1_s_addr", s_addr, 32'hB0);
    chk1 ("tie1_m1_ready", m1_ready, 1'b1);
    chk32("tie1_m1_rdata", m1_rdata, 32'h2000);
    chk1 ("tie1_m0_ready", m0_ready, 1'b0);
    chk32("tie1_m0_rdata", m0_rdata, 32'h0);
    tick(); m1_addr = 32'hB4; s_rdata = 32'h3000;
    sample(); chk1("tie2_idle_m0_ready", m0_ready, 1'b0);
    tick();
    sample(); chk32("tie2_s_addr", s_addr, 32'hA4);
    chk1 ("tie2_m0_ready", m0_ready, 1'b1);
    chk32("tie2_m0_rdata", m0_rdata, 32'h3000);
    tick(); m0_valid = 1'b0; s_rdata = 32'h4000;
    sample(); chk1("tie3_idle_m1_ready", m1_ready, 1'b0);
    tick();
    sample(); chk32("tie3_s_addr", s_addr, 32'hB4);
    chk1 ("tie3_m1_ready", m1_ready, 1'b1);
    chk32("tie3_m1_rdata", m1_rdata, 32'h4000);
    tick(); m1_valid = 1'b0; s_ready = 1'b0;

    // m1 read answered exactly in the expiry cycle: normal completion
    tick(); m1_valid = 1'b1; m1_addr = 32'h40;
    tick();
    sample(); chk1("exp_b1_m1_ready", m1_ready, 1'b0);
    tick();
    tick();
    sample(); chk1("exp_b3_m1_ready", m1_ready, 1'b0);
    tick(); s_ready = 1'b1; s_rdata = 32'hCAFE0001;
    sample(); chk1("exp_b4_m1_ready", m1_ready, 1'b1);
    chk32("exp_b4_m1_rdata", m1_rdata, 32'hCAFE0001);
    tick(); m1_valid = 1'b0; s_ready = 1'b0;
    sample(); chk1("exp_after_timeout_err", timeout_err, 1'b0);

    // m0 read with no slave response: watchdog completes in the 4th BUSY cycle
    tick(); m0_valid = 1'b1; m0_addr = 32'h80; s_rdata = 32'h12341234;
    tick();
    sample(); chk1("to_b1_s_valid", s_valid, 1'b1);
    chk1 ("to_b1_m0_ready", m0_ready, 1'b0);
    tick();
    tick();
    sample(); chk1("to_b3_m0_ready", m0_ready, 1'b0);
    chk1 ("to_b3_timeout_err", timeout_err, 1'b0);
    tick();
    sample(); chk1("to_b4_m0_ready", m0_ready, 1'b1);
    chk32("to_b4_m0_rdata", m0_rdata, 32'h0);
    chk1 ("to_b4_timeout_err", timeout_err, 1'b0);
    tick(); m0_valid = 1'b0; s_ready = 1'b1;
    sample(); chk1("to_idle_timeout_err", timeout_err, 1'b1);
    chk1 ("to_idle_s_valid", s_valid, 1'b0);
    chk1 ("to_late_m0_ready", m0_ready, 1'b0);
    chk1 ("to_late_m1_ready", m1_ready, 1'b0);
    tick(); s_ready = 1'b0;
    sample(); chk1("to_sticky_timeout_err", timeout_err, 1'b1);

    // m1 transfer abandoned by reset; pointer must return to 1 so m0 wins the next tie
    tick(); m1_valid = 1'b1; m1_addr = 32'h60;
    tick();
    sample(); chk1("rb_b1_s_valid", s_valid, 1'b1);
    tick(); rst_n = 1'b0; m1_valid = 1'b0;
    tick(); rst_n = 1'b1;
    sample(); chk1("rb_post_s_valid", s_valid, 1'b0);
    chk1 ("rb_post_m1_ready", m1_ready, 1'b0);
    chk1 ("rb_post_timeout_err", timeout_err, 1'b0);
    tick(); m0_valid = 1'b1; m0_addr = 32'hC0; m1_valid = 1'b1; m1_addr = 32'hD0;
    tick(); s_ready = 1'b1; s_rdata = 32'h5555AAAA;
    sample(); chk32("rb_tie_s_addr", s_addr, 32'hC0);
    chk1 ("rb_tie_m0_ready", m0_ready, 1'b1);
    chk1 ("rb_tie_m1_ready", m1_ready, 1'b0);
    chk32("rb_tie_m0_rdata", m0_rdata, 32'h5555AAAA);
    tick(); m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
